// File: rtl/writeback_pkg.sv
// Shared types and helpers for the output writeback path.
//   wb_state_t  : collection FSM states
//   wb_entry_t  : one buffered result (memory address + memory-width data)
//   linear_addr : linear memory address of a result from (x, y, ch)
// Entry fields are sized for the widest supported configuration; the top
// level fills only the bits its parameters need and synthesis trims the rest.
package writeback_pkg;

    localparam int WB_MAX_AW = 32;
    localparam int WB_MAX_DW = 64;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        DONE
    } wb_state_t;

    typedef struct packed {
        logic [WB_MAX_AW-1:0] addr;
        logic [WB_MAX_DW-1:0] data;
    } wb_entry_t;

    // Full-precision address; the caller truncates to its address width,
    // so wrap-around past the top of memory is intentional.
    function automatic logic [63:0] linear_addr(
        input logic [63:0] x,
        input logic [63:0] y,
        input logic [63:0] ch,
        input logic [63:0] w,
        input logic [63:0] h,
        input logic [63:0] base
    );
        return base + (ch * h + y) * w + x;
    endfunction

endpackage

// File: rtl/output_writeback_if.sv
// Bus bundle between the result producer / memory arbiter and the writeback.
//   out, output_valid, output_x/y/ch : result stream (no back-pressure)
//   mem_grant                        : arbiter permits a write this cycle
//   mem_write_en/addr, mem_din       : external memory write port
// slave modport is the writeback block, master modport is the environment.
interface output_writeback_if #(
    parameter int DATA_W = 16,
    parameter int MEM_W  = 32,
    parameter int AW     = 20,
    parameter int XW     = 10,
    parameter int YW     = 10,
    parameter int CW     = 6
);
    logic signed [DATA_W-1:0] out;
    logic                     output_valid;
    logic [XW-1:0]            output_x;
    logic [YW-1:0]            output_y;
    logic [CW-1:0]            output_ch;
    logic                     mem_grant;
    logic                     mem_write_en;
    logic [AW-1:0]            mem_write_addr;
    logic [MEM_W-1:0]         mem_din;

    modport slave (
        input  out, output_valid, output_x, output_y, output_ch, mem_grant,
        output mem_write_en, mem_write_addr, mem_din
    );

    modport master (
        output out, output_valid, output_x, output_y, output_ch, mem_grant,
        input  mem_write_en, mem_write_addr, mem_din
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage.
//   clk, rst     : clock, asynchronous active-high reset
//   clear        : synchronous flush of the pointers
//   push, din    : write side; a push while full is accepted only with a pop
//   pop, dout    : read side; dout shows the head entry combinationally
//   full, empty  : occupancy flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit separates full from empty when indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the one being popped this cycle;
    // the head is read before the edge so the old entry is not lost.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/output_writeback.sv
// Collects one output feature map from the accelerator result stream and
// writes it to external memory at linear addresses, throttled by mem_grant.
//   clk, arst_in        : clock, asynchronous active-high reset
//   start               : arms a new collection (from IDLE or DONE)
//   bus (slave modport) : result stream in, memory write port out
//   busy                : collection or drain in progress
//   done                : sticky, full map written
//   overflow            : sticky, a result was dropped on a full buffer
module output_writeback
    import writeback_pkg::*;
#(
    parameter int IO_DATA_WIDTH      = 16,
    parameter int EXT_MEM_WIDTH      = 32,
    parameter int EXT_MEM_HEIGHT     = 1 << 20,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int FIFO_DEPTH         = 8,
    parameter int BASE_ADDR          = 0
) (
    input  logic                clk,
    input  logic                arst_in,
    input  logic                start,
    output_writeback_if.slave   bus,
    output logic                busy,
    output logic                done,
    output logic                overflow
);
    localparam int AW = $clog2(EXT_MEM_HEIGHT);
    localparam longint unsigned N =
        longint'(FEATURE_MAP_WIDTH) * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS;
    localparam int CNT_W = $clog2(N + 1);

    wb_state_t          state, next_state;
    logic [CNT_W-1:0]   in_count, out_count;
    logic               push_req, pop, drop, arm, last_in;
    logic               fifo_full, fifo_empty;
    wb_entry_t          push_entry, head_entry;
    logic [63:0]        addr_full;
    logic [EXT_MEM_WIDTH-1:0] ext_data;
    logic               head_unused;
    logic               write_en_q;
    logic [AW-1:0]      write_addr_q;
    logic [EXT_MEM_WIDTH-1:0] din_q;

    assign push_req = (state == COLLECT) && bus.output_valid;
    assign pop      = !fifo_empty && bus.mem_grant;
    assign drop     = push_req && fifo_full && !pop;
    assign arm      = start && (state == IDLE || state == DONE);
    assign last_in  = push_req && (in_count == CNT_W'(N - 1));

    assign addr_full = linear_addr(64'(bus.output_x), 64'(bus.output_y), 64'(bus.output_ch),
                                   64'(FEATURE_MAP_WIDTH), 64'(FEATURE_MAP_HEIGHT),
                                   64'(BASE_ADDR));
    assign ext_data  = EXT_MEM_WIDTH'(signed'(bus.out));
    assign push_entry.addr = WB_MAX_AW'(addr_full[AW-1:0]);
    assign push_entry.data = WB_MAX_DW'(ext_data);
    assign head_unused     = ^head_entry;

    sync_fifo #(.WIDTH($bits(wb_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (arst_in),
        .clear (arm),
        .push  (push_req),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) state <= IDLE;
        else         state <= next_state;
    end

    // Drain finishes only once every counted result has been retired and
    // the buffer is empty, so the last write has already been issued.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = COLLECT;
            COLLECT: if (last_in) next_state = DRAIN;
            DRAIN:   if (fifo_empty && out_count == CNT_W'(N)) next_state = DONE;
            DONE:    if (start) next_state = COLLECT;
            default: next_state = IDLE;
        endcase
    end

    // A dropped result is retired on the spot so out_count still reaches N
    // and a map with overflow can complete.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            in_count  <= '0;
            out_count <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            busy <= (next_state == COLLECT) || (next_state == DRAIN);
            if (arm) begin
                in_count  <= '0;
                out_count <= '0;
                done      <= 1'b0;
                overflow  <= 1'b0;
            end else begin
                if (push_req)    in_count  <= in_count + 1'b1;
                if (pop || drop) out_count <= out_count + 1'b1;
                if (drop)        overflow  <= 1'b1;
                if (state == DRAIN && next_state == DONE) done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            din_q        <= '0;
        end else begin
            write_en_q <= pop;
            if (pop) begin
                write_addr_q <= head_entry.addr[AW-1:0];
                din_q        <= head_entry.data[EXT_MEM_WIDTH-1:0];
            end
        end
    end

    assign bus.mem_write_en   = write_en_q;
    assign bus.mem_write_addr = write_addr_q;
    assign bus.mem_din        = din_q;

endmodule

// File: tb/tb_output_writeback.sv
// Self-checking bench for output_writeback with W=4, H=2, OC=2, FIFO depth 4.
// A queue-based reference model predicts every write, busy, done and overflow.
module tb_output_writeback;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int OC    = 2;
    localparam int N     = W * H * OC;
    localparam int DEPTH = 4;
    localparam int BASE  = 100;
    localparam int MH    = 1 << 20;
    localparam int AW    = 20;

    typedef struct {
        int unsigned addr;
        int unsigned data;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy, done, overflow;

    output_writeback_if #(.DATA_W(16), .MEM_W(32), .AW(AW), .XW(2), .YW(1), .CW(1)) bus ();

    output_writeback #(
        .IO_DATA_WIDTH(16), .EXT_MEM_WIDTH(32), .EXT_MEM_HEIGHT(MH),
        .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .OUTPUT_NB_CHANNELS(OC),
        .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .clk      (clk),
        .arst_in  (rst),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    ent_t        mq[$];
    bit          m_active, m_accept, m_done, m_ovf;
    int          m_in, m_retired;
    bit          exp_we;
    int unsigned exp_addr, exp_din;
    int          errors, checks, writes_seen;

    function automatic int unsigned sext(int unsigned v);
        return (v >= 32768) ? v + 32'hFFFF0000 : v;
    endfunction

    function automatic int unsigned addr_of(int unsigned x, int unsigned y, int unsigned ch);
        return (BASE + (ch * H + y) * W + x) % MH;
    endfunction

    task automatic checkValue(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference model: one call per clock edge with the inputs seen at it.
    task automatic modelEdge(bit v, int unsigned x, int unsigned y, int unsigned ch,
                             int unsigned d, bit g, bit s);
        int   sz;
        bit   popped;
        bit   was_active, was_accept;
        int   ret_before;
        ent_t e;
        sz         = mq.size();
        popped     = (sz > 0) && g;
        was_active = m_active;
        was_accept = m_accept;
        ret_before = m_retired;
        exp_we     = popped;
        if (popped) begin
            e        = mq.pop_front();
            exp_addr = e.addr;
            exp_din  = e.data;
            m_retired++;
        end
        if (was_accept && v) begin
            m_in++;
            if (sz < DEPTH || popped) begin
                e.addr = addr_of(x, y, ch);
                e.data = sext(d);
                mq.push_back(e);
            end else begin
                m_ovf = 1'b1;
                m_retired++;
            end
            if (m_in == N) m_accept = 1'b0;
        end
        if (was_active && !was_accept && sz == 0 && ret_before == N) begin
            m_active = 1'b0;
            m_done   = 1'b1;
        end
        if (s && !was_active) begin
            m_active  = 1'b1;
            m_accept  = 1'b1;
            m_done    = 1'b0;
            m_ovf     = 1'b0;
            m_in      = 0;
            m_retired = 0;
            mq.delete();
        end
    endtask

    task automatic checkOutput();
        checkValue("mem_write_en", bus.mem_write_en, exp_we);
        if (exp_we) begin
            checkValue("mem_write_addr", bus.mem_write_addr, exp_addr);
            checkValue("mem_din", bus.mem_din, exp_din);
        end
        if (bus.mem_write_en === 1'b1) writes_seen++;
        checkValue("busy", busy, m_active);
        checkValue("done", done, m_done);
        checkValue("overflow", overflow, m_ovf);
    endtask

    task automatic applyStimulus(bit v, int unsigned x, int unsigned y, int unsigned ch,
                                 int unsigned d, bit g, bit s);
        bus.output_valid = v;
        bus.output_x     = 2'(x);
        bus.output_y     = 1'(y);
        bus.output_ch    = 1'(ch);
        bus.out          = 16'(d);
        bus.mem_grant    = g;
        start            = s;
        @(posedge clk);
        modelEdge(v, x, y, ch, d, g, s);
        #1;
        checkOutput();
    endtask

    task automatic sendResult(int idx, int unsigned d, bit g);
        applyStimulus(1'b1, idx % W, (idx / W) % H, idx / (W * H), d, g, 1'b0);
    endtask

    task automatic drainUntilDone(int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            applyStimulus(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
            k++;
        end
        checkValue("drain_reaches_done", done, 1'b1);
    endtask

    task automatic doReset(string tag);
        rst = 1'b1;
        #1;
        checkValue({tag, "_we"}, bus.mem_write_en, 1'b0);
        checkValue({tag, "_addr"}, bus.mem_write_addr, 0);
        checkValue({tag, "_din"}, bus.mem_din, 0);
        checkValue({tag, "_busy"}, busy, 1'b0);
        checkValue({tag, "_done"}, done, 1'b0);
        checkValue({tag, "_overflow"}, overflow, 1'b0);
        m_active = 0; m_accept = 0; m_done = 0; m_ovf = 0;
        m_in = 0; m_retired = 0; exp_we = 0;
        mq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int sent;
        int guard;
        bit v, g;
        errors = 0; checks = 0; writes_seen = 0;
        start = 1'b0;
        bus.output_valid = 1'b0; bus.output_x = '0; bus.output_y = '0;
        bus.output_ch = '0; bus.out = '0; bus.mem_grant = 1'b0;

        doReset("reset");

        // Basic raster run with out = -3 and grant held high.
        writes_seen = 0;
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
        for (int i = 0; i < N; i++) sendResult(i, 16'hFFFD, 1'b1);
        drainUntilDone(20);
        checkValue("basic_write_count", writes_seen, N);
        checkValue("addr_map_x3y1ch1", bus.mem_write_addr, 115);
        checkValue("basic_din_minus3", bus.mem_din, 32'hFFFFFFFD);
        checkValue("basic_no_overflow", overflow, 1'b0);

        // Results after done are ignored; a new start rearms.
        writes_seen = 0;
        for (int i = 0; i < 3; i++) sendResult(i, $urandom_range(0, 65535), 1'b1);
        checkValue("ignore_after_done", writes_seen, 0);
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
        checkValue("restart_busy", busy, 1'b1);
        checkValue("restart_done_clear", done, 1'b0);

        // Back-pressure: four results held, then released back to back.
        for (int i = 0; i < 4; i++) sendResult(i, $urandom_range(0, 65535), 1'b0);
        writes_seen = 0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
        checkValue("backpressure_writes", writes_seen, 4);
        checkValue("backpressure_no_overflow", overflow, 1'b0);
        sent = 4;
        guard = 0;
        while (sent < N && guard < 500) begin
            v = ($urandom_range(0, 3) != 0);
            g = ($urandom_range(0, 3) != 0);
            if (v) begin
                sendResult(sent, $urandom_range(0, 65535), g);
                sent++;
            end else begin
                applyStimulus(1'b0, 0, 0, 0, 0, g, 1'b0);
            end
            guard++;
        end
        drainUntilDone(40);

        // Overflow: five results into a four-entry buffer with no grant.
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
        writes_seen = 0;
        for (int i = 0; i < 5; i++) sendResult(i, $urandom_range(0, 65535), 1'b0);
        checkValue("overflow_set", overflow, 1'b1);
        for (int i = 5; i < N; i++) sendResult(i, $urandom_range(0, 65535), 1'b1);
        drainUntilDone(20);
        checkValue("overflow_write_count", writes_seen, N - 1);
        checkValue("overflow_sticky", overflow, 1'b1);

        // Reset mid-run drops buffered results; idle ignores the stream.
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) sendResult(i, $urandom_range(0, 65535), 1'b0);
        doReset("midrun_reset");
        writes_seen = 0;
        for (int i = 0; i < 4; i++) sendResult(i, $urandom_range(0, 65535), 1'b1);
        checkValue("idle_no_writes", writes_seen, 0);
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
        for (int i = 0; i < N; i++) sendResult(i, $urandom_range(0, 65535), 1'b1);
        drainUntilDone(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/output_writeback.md
# output_writeback

Downstream consumer of the accelerator chip's result stream (`out`, `output_valid`, `output_x/y/ch`). It buffers each result in a small FIFO, sign-extends it to memory width, computes its linear address and writes it into a shared external-style memory write port, throttled by an arbiter grant. It counts results and stops after one full output feature map, reporting completion and any overflow.

## Interface

- IO_DATA_WIDTH, 16, width of incoming result
- EXT_MEM_WIDTH, 32, memory word width; must be ≥ IO_DATA_WIDTH
- EXT_MEM_HEIGHT, 1<<20, memory depth; address width AW = $clog2(EXT_MEM_HEIGHT)
- FEATURE_MAP_WIDTH, 1024, W
- FEATURE_MAP_HEIGHT, 1024, H
- OUTPUT_NB_CHANNELS, 64, OC
- FIFO_DEPTH, 8, result buffer entries; power of two, ≥ 2
- BASE_ADDR, 0, first memory address of the output map

Ports:

- clk  in  1  single clock, rising edge
- arst_in  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; arms a new collection
- out  in  IO_DATA_WIDTH  signed result
- output_valid  in  1  result strobe; no back-pressure exists upstream
- output_x  in  $clog2(W)  column
- output_y  in  $clog2(H)  row
- output_ch  in  $clog2(OC)  output channel
- mem_grant  in  1  arbiter permits a write this cycle
- mem_write_en  out  1  write strobe
- mem_write_addr  out  AW  write address
- mem_din  out  EXT_MEM_WIDTH  write data
- busy  out  1  collection in progress
- done  out  1  sticky; full map written
- overflow  out  1  sticky; a result was dropped

## Operation

- States: IDLE, COLLECT, DRAIN, DONE. Reset → IDLE.
- IDLE: results ignored. start → COLLECT; clears in-count, out-count, done, overflow, and FIFO pointers.
- COLLECT: each output_valid pushes {sign-extended out, address} into the FIFO. Address = BASE_ADDR + (ch·H + y)·W + x, computed at full precision, then truncated modulo 2^AW (wrap-around is legal, not flagged). in-count increments per accepted or dropped result.
- When in-count reaches N = W·H·OC, go to DRAIN. Results arriving in DRAIN/DONE/IDLE are ignored and do not set overflow.
- Pop: FIFO non-empty and mem_grant → present the entry on the registered write outputs the next cycle; out-count increments.
- DRAIN: when FIFO is empty and out-count == N, go to DONE. done is set on the same edge.
- DONE: done stays high. start → COLLECT with counters and flags cleared.
- start while in COLLECT or DRAIN: ignored.
- Full FIFO: a push with no simultaneous pop drops the result, sets overflow, and still counts toward in-count. With push and pop in the same cycle, the push is accepted even when the FIFO is full.
- Empty FIFO with mem_grant high: no write.
- Counter widths: $clog2(N+1) bits.

## Timing

- Reset values: mem_write_en=0, mem_write_addr=0, mem_din=0, busy=0, done=0, overflow=0.
- busy = (state is COLLECT or DRAIN), registered; it rises one cycle after start.
- Latency: output_valid at cycle t into an empty FIFO with mem_grant high at t+1 gives mem_write_en high during cycle t+2 (2 cycles).
- mem_write_en is high for exactly one cycle per popped entry. The maximum rate is one write per cycle.
- mem_grant low holds entries; it never drops them.
- Asserting arst_in mid-operation immediately clears all state. Buffered results are lost and no write strobe is produced.

## Structure

- Shared package `writeback_pkg`:
  - state enum `wb_state_t`
  - FIFO entry struct `wb_entry_t` {addr, data}
  - function computing the linear address from x, y, ch and the parameters
- Sub-module `sync_fifo`: parameterised width/depth, push/pop/full/empty, registered storage, supports simultaneous push+pop when full.
- Top level holds the FSM, counters, sign extension and output registers.

## Test plan

All scenarios use W=4, H=2, OC=2 (N=16), FIFO_DEPTH=4, BASE_ADDR=100, EXT_MEM_WIDTH=32, IO_DATA_WIDTH=16.

- Basic: start, then 16 results in raster order (ch,y,x) with out=-3 and mem_grant held high → 16 writes at addresses 100..115 with mem_din=0xFFFFFFFD. done=1 and overflow=0 after the last write. Each write appears 2 cycles after its valid.
- Address mapping: single result x=3, y=1, ch=1 → mem_write_addr=100+(1·2+1)·4+3=115.
- Back-pressure: mem_grant=0 while 4 results arrive, then mem_grant=1 → 4 writes in order on consecutive cycles with no loss and overflow=0.
- Overflow: mem_grant=0, 5 results → overflow=1. The first 4 are written after grant; in-count still reaches N so that done is reachable.
- Wrap/ignore: after done, further output_valid pulses → no writes, done stays 1. A new start → done=0 and busy=1 on the next cycle.
- Reset mid-run: assert arst_in after 6 results with grant low → all outputs 0 and state IDLE. Results after release produce no writes until start.
